// File: rtl/dmem_stage_if.sv
// Bus between the pipeline memory stage and the data-memory block.
// The master modport is the pipeline side. The slave modport is dmem_stage.
interface dmem_stage_if;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] DmmRD;
    logic        MemStallM;
    logic        MisalignM;

    modport master (
        output MemWriteM, MemtoRegM, ALUOutM, WriteDataM,
        input  DmmRD, MemStallM, MisalignM
    );

    modport slave (
        input  MemWriteM, MemtoRegM, ALUOutM, WriteDataM,
        output DmmRD, MemStallM, MisalignM
    );
endinterface

// File: rtl/dmem_stage.sv
// Data-memory block with a configurable number of wait states.
// Sits after the pipeline memory stage and raises MemStallM until each
// access completes. Load data is presented only in the completion cycle.
// Optional feature macro: DMEM_STATS_EN adds the AccessCount and StallCount
// ports, which count completed accesses and stall cycles.
module dmem_stage #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    dmem_stage_if.slave  dmemBus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]  AccessCount,
    output logic [31:0]  StallCount
`endif
);
    localparam int         WORDS     = 1 << DEPTH_LOG2;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    // The acceptance cycle counts as the first stall cycle.
    // WAIT therefore covers the remaining WAIT_CYCLES-1 cycles.
    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, stateNext;
    logic [3:0]            waitCnt, waitCntNext;
    logic                  stallComb, accept;

    logic [DEPTH_LOG2-1:0] idxQ;
    logic [31:0]           dataQ;
    logic                  storeQ, loadQ, misQ;
    logic                  misalignFlag;

    logic [31:0]           mem [WORDS];

    // Live request decode. A request with both MemWriteM and MemtoRegM high is a store.
    logic                  req, liveStore, liveLoad, liveMis;
    logic [DEPTH_LOG2-1:0] liveIdx;
    logic                  unusedAddrHi;

    assign req          = dmemBus.MemWriteM | dmemBus.MemtoRegM;
    assign liveStore    = dmemBus.MemWriteM;
    assign liveLoad     = dmemBus.MemtoRegM & ~dmemBus.MemWriteM;
    assign liveMis      = |dmemBus.ALUOutM[1:0];
    assign liveIdx      = dmemBus.ALUOutM[DEPTH_LOG2+1:2];
    // The upper address bits are ignored, so addresses wrap (alias) onto the array.
    assign unusedAddrHi = &{1'b0, dmemBus.ALUOutM[31:DEPTH_LOG2+2]};

    // With zero wait states the access completes in the request cycle and uses
    // the live inputs. Otherwise it uses the values latched at acceptance.
    logic                  complete, accStore, accLoad, accMis, writeEn;
    logic [DEPTH_LOG2-1:0] accIdx;
    logic [31:0]           accData;

    assign accIdx   = ZERO_WAIT ? liveIdx : idxQ;
    assign accData  = ZERO_WAIT ? dmemBus.WriteDataM : dataQ;
    assign accStore = ZERO_WAIT ? liveStore : storeQ;
    assign accLoad  = ZERO_WAIT ? liveLoad : loadQ;
    assign accMis   = ZERO_WAIT ? liveMis : misQ;
    assign complete = ~reset & (ZERO_WAIT ? req : (state == DONE));
    assign writeEn  = complete & accStore & ~accMis;

    assign dmemBus.DmmRD     = (complete & accLoad & ~accMis) ? mem[accIdx] : 32'd0;
    assign dmemBus.MemStallM = stallComb & ~reset;
    assign dmemBus.MisalignM = misalignFlag;

    // State register and wait-state down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Next-state logic, stall request and acceptance strobe.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        stallComb   = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (!ZERO_WAIT) begin
                        stallComb   = 1'b1;
                        stateNext   = (WAIT_CYCLES > 1) ? WAIT : DONE;
                        waitCntNext = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                stallComb = 1'b1;
                if (waitCnt == 4'd0) stateNext = DONE;
                else                 waitCntNext = waitCnt - 4'd1;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Capture the access at acceptance. Inputs are ignored until the next IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idxQ   <= '0;
            dataQ  <= 32'd0;
            storeQ <= 1'b0;
            loadQ  <= 1'b0;
            misQ   <= 1'b0;
        end else if (accept && !ZERO_WAIT) begin
            idxQ   <= liveIdx;
            dataQ  <= dmemBus.WriteDataM;
            storeQ <= liveStore;
            loadQ  <= liveLoad;
            misQ   <= liveMis;
        end
    end

    // The misaligned-access flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  misalignFlag <= 1'b0;
        else if (accept && liveMis) misalignFlag <= 1'b1;
    end

    // RAM write port. Contents are not reset.
    always_ff @(posedge clk) begin
        if (writeEn) mem[accIdx] <= accData;
    end

`ifdef DMEM_STATS_EN
    // Free-running statistics counters that wrap at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AccessCount <= 32'd0;
            StallCount  <= 32'd0;
        end else begin
            if (complete)          AccessCount <= AccessCount + 32'd1;
            if (dmemBus.MemStallM) StallCount  <= StallCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage.
// The main instance uses two wait states. A second instance uses zero wait states.
module tb_dmem_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;

    logic [2:0]  obsStall;
    logic [31:0] obsRd;
    logic        obsRdLeak;

    dmem_stage_if dutBus ();
    dmem_stage_if zwBus ();

`ifdef DMEM_STATS_EN
    logic [31:0] dutAcc, dutStl, zwAcc, zwStl;
`endif

    dmem_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .dmemBus(dutBus)
`ifdef DMEM_STATS_EN
        , .AccessCount(dutAcc), .StallCount(dutStl)
`endif
    );

    dmem_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) zw (
        .clk(clk), .reset(reset), .dmemBus(zwBus)
`ifdef DMEM_STATS_EN
        , .AccessCount(zwAcc), .StallCount(zwStl)
`endif
    );

    always #5 clk = ~clk;

    // Drive one access on the two-wait-state instance and sample its three cycles.
    // The call starts and ends 1 time unit after a rising edge. The request stays
    // asserted afterwards, so consecutive calls form back-to-back accesses.
    task automatic runAccess(input logic st, input logic ld, input logic [31:0] addr,
                             input logic [31:0] data);
        dutBus.MemWriteM  = st;
        dutBus.MemtoRegM  = ld;
        dutBus.ALUOutM    = addr;
        dutBus.WriteDataM = data;
        obsRdLeak = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obsStall[i] = dutBus.MemStallM;
            if (i == 2) obsRd = dutBus.DmmRD;
            else if (dutBus.DmmRD !== 32'd0) obsRdLeak = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycle();
        dutBus.MemWriteM = 1'b0;
        dutBus.MemtoRegM = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dutBus.MemWriteM = 1'b1;
        dutBus.MemtoRegM = 1'b0;
        dutBus.ALUOutM = 32'h10;
        dutBus.WriteDataM = 32'h0;
        @(negedge clk);
        checks++;
        if (dutBus.MemStallM !== 1'b0) begin fails++; $display("FAIL reset_stall got %b expected 0", dutBus.MemStallM); end
        checks++;
        if (dutBus.DmmRD !== 32'd0) begin fails++; $display("FAIL reset_rd got %h expected 00000000", dutBus.DmmRD); end
        checks++;
        if (dutBus.MisalignM !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b expected 0", dutBus.MisalignM); end
`ifdef DMEM_STATS_EN
        checks++;
        if (dutAcc !== 32'd0 || dutStl !== 32'd0) begin fails++; $display("FAIL reset_stats got %h/%h expected 0/0", dutAcc, dutStl); end
`endif
        dutBus.MemWriteM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        runAccess(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++;
        if (obsStall !== 3'b011) begin fails++; $display("FAIL store10_stall got %b expected 011", obsStall); end
        checks++;
        if (obsRd !== 32'd0 || obsRdLeak) begin fails++; $display("FAIL store10_rd got %h leak %b expected 00000000", obsRd, obsRdLeak); end
        runAccess(1'b0, 1'b1, 32'h10, 32'h0);
        checks++;
        if (obsStall !== 3'b011) begin fails++; $display("FAIL load10_stall got %b expected 011", obsStall); end
        checks++;
        if (obsRd !== 32'hDEADBEEF) begin fails++; $display("FAIL load10_rd got %h expected deadbeef", obsRd); end
        checks++;
        if (obsRdLeak) begin fails++; $display("FAIL load10_early_rd got nonzero expected 00000000"); end
        idleCycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq;
        runAccess(1'b1, 1'b0, 32'h20, 32'h11111111);
        seq[2:0] = obsStall;
        runAccess(1'b1, 1'b0, 32'h24, 32'h22222222);
        seq[5:3] = obsStall;
        checks++;
        if (seq !== 6'b011011) begin fails++; $display("FAIL b2b_stall got %b expected 011011", seq); end
        idleCycle();
        runAccess(1'b0, 1'b1, 32'h20, 32'h0);
        checks++;
        if (obsRd !== 32'h11111111) begin fails++; $display("FAIL load20_rd got %h expected 11111111", obsRd); end
        runAccess(1'b0, 1'b1, 32'h24, 32'h0);
        checks++;
        if (obsRd !== 32'h22222222) begin fails++; $display("FAIL load24_rd got %h expected 22222222", obsRd); end
        // With both strobes high the access is a store and no load data is returned.
        runAccess(1'b1, 1'b1, 32'h28, 32'h33333333);
        checks++;
        if (obsRd !== 32'd0) begin fails++; $display("FAIL bothstrobe_rd got %h expected 00000000", obsRd); end
        runAccess(1'b0, 1'b1, 32'h28, 32'h0);
        checks++;
        if (obsRd !== 32'h33333333) begin fails++; $display("FAIL load28_rd got %h expected 33333333", obsRd); end
        idleCycle();
    endtask

    task automatic test_misalign();
        checks++;
        if (dutBus.MisalignM !== 1'b0) begin fails++; $display("FAIL misalign_pre got %b expected 0", dutBus.MisalignM); end
        runAccess(1'b1, 1'b0, 32'h13, 32'h12345678);
        checks++;
        if (obsStall !== 3'b011) begin fails++; $display("FAIL mis_stall got %b expected 011", obsStall); end
        checks++;
        if (dutBus.MisalignM !== 1'b1) begin fails++; $display("FAIL mis_flag got %b expected 1", dutBus.MisalignM); end
        runAccess(1'b0, 1'b1, 32'h10, 32'h0);
        checks++;
        if (obsRd !== 32'hDEADBEEF) begin fails++; $display("FAIL mis_load10 got %h expected deadbeef", obsRd); end
        runAccess(1'b0, 1'b1, 32'h11, 32'h0);
        checks++;
        if (obsRd !== 32'd0) begin fails++; $display("FAIL mis_load_rd got %h expected 00000000", obsRd); end
        idleCycle();
        checks++;
        if (dutBus.MisalignM !== 1'b1) begin fails++; $display("FAIL mis_sticky got %b expected 1", dutBus.MisalignM); end
    endtask

    task automatic test_alias();
        runAccess(1'b1, 1'b0, 32'h400, 32'hA5A5A5A5);
        runAccess(1'b0, 1'b1, 32'h000, 32'h0);
        checks++;
        if (obsRd !== 32'hA5A5A5A5) begin fails++; $display("FAIL alias_rd got %h expected a5a5a5a5", obsRd); end
        idleCycle();
    endtask

    task automatic test_reset_mid();
        runAccess(1'b1, 1'b0, 32'h30, 32'h01020304);
        dutBus.ALUOutM = 32'h30;
        dutBus.WriteDataM = 32'h55AA55AA;
        dutBus.MemWriteM = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (dutBus.MemStallM !== 1'b1) begin fails++; $display("FAIL midrst_wait_stall got %b expected 1", dutBus.MemStallM); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (dutBus.MemStallM !== 1'b0) begin fails++; $display("FAIL midrst_stall got %b expected 0", dutBus.MemStallM); end
        checks++;
        if (dutBus.MisalignM !== 1'b0) begin fails++; $display("FAIL midrst_misalign got %b expected 0", dutBus.MisalignM); end
        dutBus.MemWriteM = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        runAccess(1'b0, 1'b1, 32'h30, 32'h0);
        checks++;
        if (obsRd !== 32'h01020304) begin fails++; $display("FAIL midrst_load got %h expected 01020304", obsRd); end
        idleCycle();
    endtask

    task automatic test_zero_wait();
        zwBus.MemWriteM = 1'b1;
        zwBus.MemtoRegM = 1'b0;
        zwBus.ALUOutM = 32'h8;
        zwBus.WriteDataM = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (zwBus.MemStallM !== 1'b0 || zwBus.DmmRD !== 32'd0) begin fails++; $display("FAIL zw_store got stall %b rd %h expected 0/00000000", zwBus.MemStallM, zwBus.DmmRD); end
        @(posedge clk);
        #1;
        zwBus.MemWriteM = 1'b0;
        zwBus.MemtoRegM = 1'b1;
        @(negedge clk);
        checks++;
        if (zwBus.MemStallM !== 1'b0 || zwBus.DmmRD !== 32'hCAFEF00D) begin fails++; $display("FAIL zw_load got stall %b rd %h expected 0/cafef00d", zwBus.MemStallM, zwBus.DmmRD); end
        @(posedge clk);
        #1;
        zwBus.MemtoRegM = 1'b0;
        @(negedge clk);
        checks++;
        if (zwBus.DmmRD !== 32'd0) begin fails++; $display("FAIL zw_idle_rd got %h expected 00000000", zwBus.DmmRD); end
`ifdef DMEM_STATS_EN
        checks++;
        if (zwAcc !== 32'd2 || zwStl !== 32'd0) begin fails++; $display("FAIL zw_stats got %h/%h expected 2/0", zwAcc, zwStl); end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        dutBus.MemWriteM = 1'b0;
        dutBus.MemtoRegM = 1'b0;
        dutBus.ALUOutM = 32'h0;
        dutBus.WriteDataM = 32'h0;
        zwBus.MemWriteM = 1'b0;
        zwBus.MemtoRegM = 1'b0;
        zwBus.ALUOutM = 32'h0;
        zwBus.WriteDataM = 32'h0;
        obsStall = 3'b000;
        obsRd = 32'h0;
        obsRdLeak = 1'b0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_misalign();
        test_alias();
        test_reset_mid();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
